sram_100_qsys_cpu_mult_seq: RTL

//  Parametrised iterative multiplier for the CPU custom-mul path. It generalises the fixed 32-bit
//  low-word multiply cell to any DATA_W and adds RISC-style high-word modes (signed, signed x unsigned,

---
 rtl/sram_100_qsys_cpu_mult_pkg.sv | 28 ++
 rtl/sram_100_qsys_cpu_mult_pp.sv | 15 +
 rtl/sram_100_qsys_cpu_mult_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sram_100_qsys_cpu_mult_pkg.sv
// Shared definitions for the sequential CPU multiplier.
//   - mode encodings (low word and the three high-word variants)
//   - FSM state type
//   - slice_count(): number of PART_W slices per DATA_W operand
package sram_100_qsys_cpu_mult_pkg;

  localparam logic [1:0] MODE_MUL    = 2'd0;  // low word, sign-independent
  localparam logic [1:0] MODE_MULH   = 2'd1;  // high word, signed x signed
  localparam logic [1:0] MODE_MULHSU = 2'd2;  // high word, signed x unsigned
  localparam logic [1:0] MODE_MULHU  = 2'd3;  // high word, unsigned x unsigned

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Operation context captured at start; operands are free to change afterwards.
  typedef struct packed {
    logic [1:0] mode;
    logic       neg;
  } op_ctx_t;

  function automatic int slice_count(input int data_w, input int part_w);
    return data_w / part_w;
  endfunction

endpackage

// File: rtl/sram_100_qsys_cpu_mult_pp.sv
// Unsigned W x W -> 2W partial-product multiplier. Purely combinational;
// intended to map onto a single DSP multiplier.
//   a, b : W-bit unsigned slices
//   p    : 2W-bit product
module sram_100_qsys_cpu_mult_pp #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/sram_100_qsys_cpu_mult_seq.sv
// Iterative DATA_W x DATA_W multiplier sharing one PART_W x PART_W multiplier
// across all P*P partial products. Operands are reduced to magnitudes at start,
// multiplied unsigned, and the sign is restored in a single fix-up cycle.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : request, sampled only when idle
//   mode         : MUL / MULH / MULHSU / MULHU
//   src1, src2   : operands, captured on the accepting edge
//   busy         : operation in flight (ACC and FIX states)
//   done         : one-cycle pulse, result valid
//   result       : selected product word, held until the next done
module sram_100_qsys_cpu_mult_seq
  import sram_100_qsys_cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PART_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int P     = slice_count(DATA_W, PART_W);
  localparam int ACC_W = 2 * DATA_W;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(P - 1);

  if (DATA_W % PART_W != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of PART_W");
  end

  state_e             state;
  op_ctx_t            ctx;
  logic [DATA_W-1:0]  mag1, mag2;
  logic [ACC_W-1:0]   acc, acc_nxt, prod;
  logic [IDX_W-1:0]   i_idx, j_idx;   // slice indices of src1 / src2
  logic [PART_W-1:0]  a_sl, b_sl;
  logic [2*PART_W-1:0] pp;
  logic               sgn1, sgn2;
  int                 sh;

  // Operand signs by mode; MUL is treated as unsigned since its low word
  // does not depend on signedness.
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (mode)
      MODE_MULH: begin
        sgn1 = src1[DATA_W-1];
        sgn2 = src2[DATA_W-1];
      end
      MODE_MULHSU: sgn1 = src1[DATA_W-1];
      default: ;
    endcase
  end

  assign a_sl = mag1[i_idx*PART_W +: PART_W];
  assign b_sl = mag2[j_idx*PART_W +: PART_W];

  sram_100_qsys_cpu_mult_pp #(.W(PART_W)) u_pp (
    .a (a_sl),
    .b (b_sl),
    .p (pp)
  );

  always_comb begin
    sh      = PART_W * (int'(i_idx) + int'(j_idx));
    acc_nxt = acc + (ACC_W'(pp) << sh);
  end

  // Magnitude product fits in ACC_W bits, so negation here is exact.
  assign prod = ctx.neg ? -acc : acc;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      ctx    <= '0;
      mag1   <= '0;
      mag2   <= '0;
      acc    <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ctx.mode <= mode;
          ctx.neg  <= sgn1 ^ sgn2;
          // Negating the most-negative value yields 2^(DATA_W-1), which is
          // still representable as an unsigned DATA_W magnitude.
          mag1     <= sgn1 ? -src1 : src1;
          mag2     <= sgn2 ? -src2 : src2;
          acc      <= '0;
          i_idx    <= '0;
          j_idx    <= '0;
          state    <= ACC;
        end
        ACC: begin
          acc <= acc_nxt;
          if (i_idx == LAST) begin
            i_idx <= '0;
            if (j_idx == LAST) state <= FIX;
            else               j_idx <= j_idx + 1'b1;
          end else begin
            i_idx <= i_idx + 1'b1;
          end
        end
        FIX: begin
          result <= (ctx.mode == MODE_MUL) ? prod[DATA_W-1:0] : prod[ACC_W-1:DATA_W];
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
